hilo_muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with its HI/LO result registers, placed beside the register file in the execute stage of the MIPS-32 core. It takes the two operand values read from the register file, computes MULT/MULTU/DIV/DIVU iteratively, and holds the result in HI/LO. Later MFHI/MFLO instructions read HI/LO from this block and return them to the register file write port. The block also accepts direct MTHI/MTLO writes.

---
 rtl/mips_pkg.sv | 19 +
 rtl/hilo_muldiv_unit_if.sv | 26 ++
 rtl/hilo_muldiv_unit_sign_fix.sv | 23 ++
 rtl/hilo_muldiv_unit.sv | 137 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  localparam int MD_ITERATIONS = 32;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - pipeline-side bundle of the multiply/divide unit
interface hilo_muldiv_unit_if;

  logic             start;
  mips_pkg::md_op_t op;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [31:0]      wdata;
  logic             busy;
  logic             done;
  logic [31:0]      hi;
  logic [31:0]      lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_unit_sign_fix.sv
// rtl/hilo_muldiv_unit_sign_fix.sv - two's-complement correction of the magnitude result
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic               qsign,
  input  logic               rsign,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] fixed
);

  // Multiply negates the whole product; divide negates quotient and remainder separately
  always_comb begin
    fixed = raw;
    if (is_div) begin
      if (rsign) fixed[2*WIDTH-1:WIDTH] = -raw[2*WIDTH-1:WIDTH];
      if (qsign) fixed[WIDTH-1:0]       = -raw[WIDTH-1:0];
    end else if (qsign) begin
      fixed = -raw;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO registers
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITERATIONS - 1);

  md_state_t            state_q, state_d;
  md_op_t               op_q;
  logic [4:0]           cnt_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     rs_orig_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 qsign_q, rsign_q, divz_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 in_div, in_signed;
  logic [WIDTH-1:0]     mag_rs, mag_rt;
  logic                 is_div;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   fixed;

  assign in_div    = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
  assign in_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
  assign mag_rs    = (in_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
  assign mag_rt    = (in_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // One iteration: multiply adds the multiplicand on the low accumulator bit and shifts
  // right; divide shifts left and keeps the trial subtract when it does not borrow
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_q};
    if (is_div) begin
      if (diff[WIDTH]) acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {sum, acc_q[WIDTH-1:1]};
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw    (acc_q),
    .qsign  (qsign_q),
    .rsign  (rsign_q),
    .is_div (is_div),
    .fixed  (fixed)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept, fixed iteration count, single fix-up cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (bus.start) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == LAST_ITER) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q != MD_IDLE);
  end

  // Operand capture, iteration, result write-back and direct HI/LO writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      opnd_q    <= '0;
      rs_orig_q <= '0;
      acc_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            cnt_q     <= '0;
            opnd_q    <= in_div ? mag_rt : mag_rs;
            acc_q     <= {{WIDTH{1'b0}}, (in_div ? mag_rs : mag_rt)};
            rs_orig_q <= bus.rs_data;
            qsign_q   <= in_signed & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            rsign_q   <= in_signed & bus.rs_data[WIDTH-1];
            divz_q    <= (bus.rt_data == '0);
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        MD_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 5'd1;
        end
        MD_FIX: begin
          done_q <= 1'b1;
          if (is_div && divz_q) begin
            lo_q <= '1;
            hi_q <= rs_orig_q;
          end else begin
            hi_q <= fixed[2*WIDTH-1:WIDTH];
            lo_q <= fixed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation: {HI, LO}
  function automatic logic [63:0] model_result(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    p = '0;
    case (o)
      MD_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
      end
      MD_MULTU: p = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          if (o == MD_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
          end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
          end
          q  = sa / sb;
          r  = sa % sb;
          qv = q;
          rv = r;
          p  = {rv[31:0], qv[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  logic [63:0] m_res = '0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_rem  = 0;

  // Reference model: 33 busy cycles per operation, HI/LO written at the end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_res <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
        end
        m_rem <= m_rem - 1;
      end else if (bus.start) begin
        m_res  <= model_result(bus.op, bus.rs_data, bus.rt_data);
        m_busy <= 1'b1;
        m_rem  <= 33;
      end else begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", bus.busy, m_busy);
      chk("cyc_done", bus.done, m_done);
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic wait_done(output int nb, output bit seen);
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) nb++;
    end
  endtask

  task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int nb;
    bit seen;
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk);
    #2;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.rs_data = ~a; bus.rt_data = b ^ 32'h5A5A_0F0F;
    wait_done(nb, seen);
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_busy_cycles"}, nb, 33);
    chk({name, "_busy_at_done"}, bus.busy, 0);
    chk({name, "_hilo"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    int nb, ndone;
    bit seen;
    bus.start = 1'b0; bus.op = MD_MULT; bus.rs_data = '0; bus.rt_data = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(MD_MULTU, 32'd7, 32'd6, {32'h0, 32'd42}, "multu_7x6");
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mult_m3x5");
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7d2");
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "div_7dm2");
    run_op(MD_DIVU, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, "divu_by0");
    run_op(MD_DIV, 32'hFFFF_FFFB, 32'h0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "div_m5_by0");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_ovf");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
    run_op(MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100d7");

    // Direct HI/LO writes, one edge of latency
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_0001;
    @(posedge clk); #1;
    chk("mthi_hilo", {bus.hi, bus.lo}, {32'hAAAA_0001, 32'd14});
    #1 bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5555;
    @(posedge clk); #1;
    chk("mtlo_hilo", {bus.hi, bus.lo}, {32'hAAAA_0001, 32'h5555});
    #1 bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1357;
    @(posedge clk); #1;
    chk("mthilo_hilo", {bus.hi, bus.lo}, {32'h1357, 32'h1357});
    #1 bus.hi_we = 1'b0; bus.lo_we = 1'b0;

    // start wins over simultaneous MTHI/MTLO
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
    run_op(MD_MULTU, 32'd3, 32'd3, {32'h0, 32'd9}, "start_vs_mt");

    // start and MTHI during RUN are ignored
    bus.hi_we = 1'b1; bus.wdata = 32'hCAFE;
    @(posedge clk); #2 bus.hi_we = 1'b0;
    bus.start = 1'b1; bus.op = MD_MULTU; bus.rs_data = 32'd3; bus.rt_data = 32'd3;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.rs_data = 32'd100; bus.rt_data = 32'd100;
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(nb, seen);
    chk("busy_ignore_done_seen", seen, 1);
    chk("busy_ignore_hilo", {bus.hi, bus.lo}, {32'h0, 32'd9});

    // Reset mid-RUN aborts without trace
    bus.hi_we = 1'b1; bus.wdata = 32'hCAFE;
    @(posedge clk); #2 bus.hi_we = 1'b0;
    bus.start = 1'b1; bus.op = MD_MULTU; bus.rs_data = 32'h10000; bus.rt_data = 32'h10000;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_hilo_after", {bus.hi, bus.lo}, 64'h0);

    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minmin");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
